spectrum_pingpong_buf: RTL and testbench
========================================

Name: spectrum_pingpong_buf

Overview:
- Parametrised, single-clock, double-buffered (ping-pong) spectrum frame store; successor to the fixed 1024x16 dual-port spectrum RAM.
- Writer streams one FFT magnitude frame into the write bank while the display reader randomly addresses the last completed frame in the read bank.
- Banks swap atomically at frame end; the swap is deferred while the reader holds a lock, so the display never shows a torn frame.

Parameters:
- DATA_W, 16, sample width.
- ADDR_W, 10, address width per bank; DEPTH = 2**ADDR_W.
- RD_LAT, 1, read latency: 1 (RAM output) or 2 (extra output register).

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write sample valid.
- wr_ready  out  1  write accepted when wr_valid&&wr_ready.
- wr_data  in  DATA_W  sample.
- wr_last  in  1  last sample of frame.
- rd_lock  in  1  reader holds current read bank; swap deferred while high.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data valid, RD_LAT cycles after rd_en.
- frame_len  out  ADDR_W+1  sample count of frame in read bank (0..DEPTH).
- frame_ready  out  1  one-cycle pulse on each swap.
- swap_pending  out  1  high while in PENDING.

Behaviour:
- Reset: wr_bank=0, wr_cnt=0, state FILL, wr_ready=1, rd_data=0, rd_valid=0, frame_len=0, frame_ready=0, swap_pending=0; RAM contents not cleared.
- Storage: one RAM of 2*DEPTH words; physical address = {bank, addr}. The read bank is always ~wr_bank.
- FILL: each accepted sample is written at {wr_bank, wr_cnt}, then wr_cnt increments. Frame completes on an accepted sample with wr_last=1, or when wr_cnt==DEPTH-1 is accepted (forced end, no wrap into the next frame).
- On completion with rd_lock=0: at the same edge, wr_bank toggles, frame_len <= wr_cnt+1, wr_cnt <= 0, and frame_ready pulses the next cycle. State stays FILL and wr_ready stays 1.
- On completion with rd_lock=1: go to PENDING. Latch the length and set wr_ready=0 (backpressure; no sample is lost).
- PENDING: on the first cycle rd_lock=0, perform the swap as above, return to FILL and set wr_ready=1 on the next cycle. swap_pending=1 throughout PENDING.
- rd_lock is sampled in the same cycle as the completing write; there is no lookahead.
- Read: rd_data/rd_valid appear RD_LAT cycles after rd_en. If rd_addr >= frame_len at request time, rd_data=0; this also returns 0 for every read before the first frame.
- A swap that lands while a read is in flight does not corrupt that read: the bank bit is captured with the address.
- Same physical address written and read in the same cycle cannot occur, because banks are disjoint.
- Reset asserted mid-frame: the partial frame is discarded and the state returns to reset values.

Decomposition:
- Package spectrum_buf_pkg: state encoding (FILL, PENDING) and a helper for the length width (ADDR_W+1).
- Sub-module sdp_ram_1clk: simple dual-port, single-clock inferred RAM with params DATA_W and AW, registered read. Instantiated once with AW=ADDR_W+1.
- Control FSM, counters and the output pipeline live in the top module.

Test Plan:
- DEPTH=8 (ADDR_W=3), rd_lock=0: write 8 samples 0x10..0x17 with wr_last on the 8th -> frame_ready pulses once, frame_len=8; reading addr 0..7 returns 0x10..0x17 after RD_LAT cycles.
- Short frame: 5 samples 0xA0..0xA4 with last on the 5th -> frame_len=5; addr 4 returns 0xA4; addr 5..7 return 0.
- No wr_last for 8 samples: forced end at sample 8 -> swap occurs; the 9th sample lands at addr 0 of the new write bank.
- rd_lock=1 at frame end -> swap_pending=1, wr_ready=0 held 20 cycles; reads still return the old frame. Drop rd_lock -> swap next edge, frame_ready pulse, wr_ready=1 one cycle later.
- Reads before any frame, any address -> rd_data=0, rd_valid follows rd_en with latency RD_LAT (run for RD_LAT=1 and 2).
- Assert rst after 3 of 8 samples -> all outputs return to reset values; the next full frame of 0x55 reads back correctly with frame_len=8.

Source files
------------

// File: rtl/spectrum_buf_pkg.sv
// Shared types for the ping-pong spectrum frame store.
package spectrum_buf_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Frame length counts 0..DEPTH inclusive, so it needs one bit more than an address.
  function automatic int len_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port single-clock RAM: one write port, one registered read port.
module sdp_ram_1clk #(
  parameter int DATA_W = 16,
  parameter int AW     = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spectrum_pingpong_buf.sv
// Double-buffered spectrum frame store: writer fills one bank, display reads the other,
// banks swap at frame end unless the reader holds rd_lock.
module spectrum_pingpong_buf
  import spectrum_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_lock,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_ready,
  output logic              swap_pending
);

  localparam int LW    = len_w(ADDR_W);
  localparam int DEPTH = 2**ADDR_W;

  state_t            state, state_n;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [LW-1:0]     pend_len, swap_len;
  logic              we, done, do_swap, go_pend;

  assign wr_ready     = (state == FILL);
  assign swap_pending = (state == PENDING);
  assign we           = wr_valid && wr_ready;
  // A full bank ends the frame even without wr_last, so writes never wrap.
  assign done         = we && (wr_last || wr_cnt == ADDR_W'(DEPTH-1));

  always_comb begin
    state_n  = state;
    do_swap  = 1'b0;
    go_pend  = 1'b0;
    swap_len = pend_len;
    case (state)
      FILL: if (done) begin
        if (rd_lock) begin
          go_pend = 1'b1;
          state_n = PENDING;
        end else begin
          do_swap  = 1'b1;
          swap_len = LW'(wr_cnt) + LW'(1);
        end
      end
      PENDING: if (!rd_lock) begin
        do_swap = 1'b1;
        state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      frame_len   <= '0;
      pend_len    <= '0;
      frame_ready <= 1'b0;
    end else begin
      state       <= state_n;
      frame_ready <= do_swap;
      if (do_swap) begin
        wr_bank   <= ~wr_bank;
        frame_len <= swap_len;
      end
      if (go_pend) pend_len <= LW'(wr_cnt) + LW'(1);
      if (done)    wr_cnt <= '0;
      else if (we) wr_cnt <= wr_cnt + ADDR_W'(1);
    end
  end

  logic [DATA_W-1:0] ram_q, d1;
  logic              v1, ok1;

  // Bank bit is captured with the address, so a swap cannot tear an in-flight read.
  sdp_ram_1clk #(.DATA_W(DATA_W), .AW(ADDR_W+1)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({~wr_bank, rd_addr}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      ok1 <= 1'b0;
    end else begin
      v1  <= rd_en;
      ok1 <= rd_en && (LW'(rd_addr) < frame_len);
    end
  end

  // Out-of-frame reads (and anything before the first frame) return zero.
  assign d1 = ok1 ? ram_q : '0;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] d2;
      logic              v2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          d2 <= d1;
          v2 <= v1;
        end
      end
      assign rd_data  = d2;
      assign rd_valid = v2;
    end else begin : g_lat1
      assign rd_data  = d1;
      assign rd_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_spectrum_pingpong_buf.sv
// Bench for spectrum_pingpong_buf: two instances (RD_LAT 1 and 2) driven in lockstep
// and compared each cycle against a frame-level queue model.
module tb_spectrum_pingpong_buf;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_last, rd_lock, rd_en;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;

  logic          wr_ready1, rd_valid1, frame_ready1, swap_pending1;
  logic [DW-1:0] rd_data1;
  logic [AW:0]   frame_len1;
  logic          wr_ready2, rd_valid2, frame_ready2, swap_pending2;
  logic [DW-1:0] rd_data2;
  logic [AW:0]   frame_len2;

  always #5 clk = ~clk;

  spectrum_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
    .wr_last(wr_last), .rd_lock(rd_lock), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .frame_len(frame_len1),
    .frame_ready(frame_ready1), .swap_pending(swap_pending1));

  spectrum_pingpong_buf #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u2 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_data(wr_data),
    .wr_last(wr_last), .rd_lock(rd_lock), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .frame_len(frame_len2),
    .frame_ready(frame_ready2), .swap_pending(swap_pending2));

  int vectors = 0;
  int errs = 0;

  // Model: frame being assembled, frame on display, frame parked behind the lock.
  logic [DW-1:0] wq[$], shown[$], pendq[$];
  bit            pend, fr;
  bit            e1v, e2v;
  logic [DW-1:0] e1d, e2d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e2v = e1v;
    e2d = e1d;
    e1v = rd_en;
    e1d = (rd_en && int'(rd_addr) < shown.size()) ? shown[rd_addr] : '0;
    fr = 0;
    if (pend) begin
      if (!rd_lock) begin
        shown = pendq;
        fr = 1;
        pend = 0;
      end
    end else if (wr_valid) begin
      wq.push_back(wr_data);
      if (wr_last || wq.size() == DEPTH) begin
        if (rd_lock) begin
          pendq = wq;
          pend = 1;
        end else begin
          shown = wq;
          fr = 1;
        end
        wq.delete();
      end
    end
  endtask

  task automatic check_all();
    chk("wr_ready", 32'(wr_ready1), 32'(!pend));
    chk("swap_pending", 32'(swap_pending1), 32'(pend));
    chk("frame_ready", 32'(frame_ready1), 32'(fr));
    chk("frame_len", 32'(frame_len1), 32'(shown.size()));
    chk("frame_len_lat2", 32'(frame_len2), 32'(shown.size()));
    chk("rd_valid_lat1", 32'(rd_valid1), 32'(e1v));
    if (e1v) chk("rd_data_lat1", 32'(rd_data1), 32'(e1d));
    chk("rd_valid_lat2", 32'(rd_valid2), 32'(e2v));
    if (e2v) chk("rd_data_lat2", 32'(rd_data2), 32'(e2d));
  endtask

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit lk,
                     input bit re, input logic [AW-1:0] ra);
    wr_valid = v; wr_data = d; wr_last = l; rd_lock = lk; rd_en = re; rd_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cw(input bit v, input logic [DW-1:0] d, input bit l, input bit lk);
    cyc(v, d, l, lk, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)));
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 0, 0, 1, AW'(i));
    cw(0, '0, 0, 0);
    cw(0, '0, 0, 0);
  endtask

  task automatic do_reset();
    wr_valid = 0; wr_last = 0; rd_lock = 0; rd_en = 0; wr_data = '0; rd_addr = '0;
    rst = 1'b1;
    #2;
    wq.delete(); shown.delete(); pendq.delete();
    pend = 0; fr = 0; e1v = 0; e2v = 0; e1d = '0; e2d = '0;
    chk("rst_wr_ready", 32'(wr_ready1), 32'd1);
    chk("rst_frame_len", 32'(frame_len1), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready1), 32'd0);
    chk("rst_swap_pending", 32'(swap_pending1), 32'd0);
    chk("rst_rd_valid", 32'({rd_valid1, rd_valid2}), 32'd0);
    chk("rst_rd_data_lat1", 32'(rd_data1), 32'd0);
    chk("rst_rd_data_lat2", 32'(rd_data2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reads before any frame: all zero, latency 1 and 2.
    for (int i = 0; i < 8; i++) cyc(0, '0, 0, 0, 1, AW'(i));
    for (int i = 0; i < 6; i++) cw(0, '0, 0, 0);

    // Full frame with wr_last on the 8th sample.
    for (int i = 0; i < 8; i++) cw(1, DW'(16'h10 + i), i == 7, 0);
    sweep();

    // Short frame of 5.
    for (int i = 0; i < 5; i++) cw(1, DW'(16'hA0 + i), i == 4, 0);
    sweep();

    // No wr_last: forced end at 8, 9th sample starts the next frame.
    for (int i = 0; i < 9; i++) cw(1, DW'(16'hC0 + i), 0, 0);
    sweep();
    for (int i = 0; i < 2; i++) cw(1, DW'(16'hD0 + i), i == 1, 0);
    sweep();

    // Lock held at frame end: backpressure for 20 cycles, old frame still visible.
    for (int i = 0; i < 8; i++) cw(1, DW'(16'h30 + i), i == 7, i == 7);
    for (int i = 0; i < 20; i++) cyc(1, 16'hEEEE, 0, 1, 1, AW'(i % DEPTH));
    for (int i = 0; i < 3; i++) cw(1, DW'(16'h40 + i), i == 2, 0);
    sweep();

    // Reset mid-frame, then a clean frame of 0x55.
    for (int i = 0; i < 3; i++) cw(1, DW'(16'h77), 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) cw(1, 16'h0055, 0, 0);
    sweep();

    // Random traffic with random locks and reads.
    for (int i = 0; i < 400; i++)
      cw(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 5) == 0),
         1'($urandom_range(0, 3) == 0));
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
